bcd_disp_mux: RTL

Downstream consumer of the binary-to-BCD converter. Captures the four BCD digits on the converter's completion pulse and drives a 4-digit, common-anode, time-multiplexed 7-segment display. Provides optional leading-zero blanking, per-digit decimal points, and an anti-ghosting blank window at each digit change. All outputs are registered.

---
 rtl/bcd_disp_mux.sv | 103 ++++++++++
 1 files changed

// File: rtl/bcd_disp_mux.sv
// Four-digit common-anode 7-segment scan driver fed by the binary-to-BCD converter.
// Latches BCD digits on load; blank_lz and dp_in are applied live at scan time.
module bcd_disp_mux #(
    parameter int N         = 18,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic       blank_lz,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       valid
);

    localparam logic [N-3:0] BLANK_W = (N-2)'(BLANK_CYC);

    logic [N-1:0] cnt;
    logic [3:0]   dig [4];

    logic [1:0]   sel;
    logic [N-3:0] slot_pos;
    logic [3:0]   val;
    logic [3:0]   lz;
    logic [6:0]   seg;
    logic [3:0]   an_next;
    logic [7:0]   sseg_next;

    always_comb begin
        sel      = cnt[N-1:N-2];
        slot_pos = cnt[N-3:0];
        val      = dig[sel];

        // lz[i]: digit i and every more significant digit are zero
        lz[3] = (dig[3] == 4'd0);
        lz[2] = lz[3] && (dig[2] == 4'd0);
        lz[1] = lz[2] && (dig[1] == 4'd0);
        lz[0] = 1'b0;

        case (val)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase

        if (!valid) begin
            seg = 7'h3F;
        end else if (blank_lz && lz[sel]) begin
            seg = 7'h7F;
        end

        if (slot_pos < BLANK_W) begin
            an_next   = 4'hF;
            sseg_next = 8'hFF;
        end else begin
            an_next   = ~(4'b0001 << sel);
            sseg_next = {~dp_in[sel], seg};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            dig[3] <= '0;
            dig[2] <= '0;
            dig[1] <= '0;
            dig[0] <= '0;
            valid  <= 1'b0;
            an     <= '1;
            sseg   <= '1;
        end else begin
            cnt <= cnt + 1'b1;
            if (load) begin
                dig[3] <= bcd3;
                dig[2] <= bcd2;
                dig[1] <= bcd1;
                dig[0] <= bcd0;
                valid  <= 1'b1;
            end
            an   <= an_next;
            sseg <= sseg_next;
        end
    end

endmodule
